// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg
//   Shared definitions for the two-port SRAM arbiter/controller:
//   bus widths, port count and the transfer FSM state encoding.
package sram_arb_pkg;

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned NPORTS = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/sram_arb_sel.sv
// sram_arb_sel
//   Two-way request arbiter for sram_arb_ctrl. Produces a combinational grant
//   from the current request vector and remembers which port owns the
//   transfer in progress.
//   Build option: SRAM_ARB_ROUND_ROBIN_EN defined -> on simultaneous requests
//   the port not granted most recently wins (p0 first after reset);
//   undefined -> fixed priority, p0 wins.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   req[1:0]  : request vector {p1, p0}
//   take      : controller accepts the current grant this cycle
//   gnt_any   : at least one port is requesting
//   gnt_idx   : index of the port that would be granted (0 = p0, 1 = p1)
//   owner     : index of the port granted at the most recent take
module sram_arb_sel
  import sram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NPORTS-1:0] req,
  input  logic              take,
  output logic              gnt_any,
  output logic              gnt_idx,
  output logic              owner
);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // ptr names the preferred port for the next collision
  logic ptr;

  always_comb begin
    gnt_any = |req;
    if (req[0] && req[1]) gnt_idx = ptr;
    else                  gnt_idx = req[1] & ~req[0];
  end

  always_ff @(posedge clk) begin
    if (rst)       ptr <= 1'b0;
    else if (take) ptr <= ~gnt_idx;
  end
`else
  always_comb begin
    gnt_any = |req;
    gnt_idx = req[1] & ~req[0];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst)       owner <= 1'b0;
    else if (take) owner <= gnt_idx;
  end

endmodule

// File: rtl/sram_arb_ctrl.sv
// sram_arb_ctrl
//   Arbitrates two requesters onto one asynchronous SRAM. Each transfer runs
//   IDLE -> SETUP -> ACCESS (WAIT_STATES cycles) -> HOLD -> IDLE; the granted
//   port gets a one-cycle ack in HOLD. All SRAM-side outputs are registered.
//   Build option: SRAM_ARB_ROUND_ROBIN_EN (see sram_arb_sel).
// Parameters:
//   WAIT_STATES : ACCESS cycles per transfer, 1..15
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   pN_req / pN_rnw          : level request, 1=read 0=write (N = 0, 1)
//   pN_addr / pN_wdata       : byte address, write data
//   pN_ack / pN_rdata        : completion pulse, read data (held)
//   sram_addr, sram_data_o   : address and write data to SRAM
//   sram_data_oe             : enable for the bidirectional data driver
//   sram_data_i              : read data from SRAM
//   sram_ceb, sram_oeb       : active-low chip / output enable
//   sram_rnw                 : 1=read, 0=write (write strobe)
module sram_arb_ctrl
  import sram_arb_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_rnw,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_rnw,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_data_o,
  output logic              sram_data_oe,
  input  logic [DATA_W-1:0] sram_data_i,
  output logic              sram_ceb,
  output logic              sram_oeb,
  output logic              sram_rnw
);

  state_t              state, state_d;
  logic [3:0]          wcnt;
  logic                last_wait;

  logic                gnt_any, gnt_idx, owner, take;

  logic                lrnw;
  logic [ADDR_W-1:0]   laddr;
  logic [DATA_W-1:0]   lwdata;

  logic                sel_rnw, cur_rnw, cur_port;
  logic [ADDR_W-1:0]   sel_addr, cur_addr;
  logic [DATA_W-1:0]   sel_wdata, cur_wdata;

  logic                ceb_d, oeb_d, rnw_d, oe_d, ack0_d, ack1_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   do_d;

  assign take = (state == ST_IDLE) && gnt_any;

  sram_arb_sel u_sel (
    .clk     (clk),
    .rst     (rst),
    .req     ({p1_req, p0_req}),
    .take    (take),
    .gnt_any (gnt_any),
    .gnt_idx (gnt_idx),
    .owner   (owner)
  );

  // In IDLE the transfer attributes come straight from the winning port so
  // the SETUP outputs can be registered on the grant edge; afterwards the
  // latched copies are used and requester changes are ignored.
  always_comb begin
    sel_rnw   = gnt_idx ? p1_rnw   : p0_rnw;
    sel_addr  = gnt_idx ? p1_addr  : p0_addr;
    sel_wdata = gnt_idx ? p1_wdata : p0_wdata;
    if (state == ST_IDLE) begin
      cur_rnw   = sel_rnw;
      cur_addr  = sel_addr;
      cur_wdata = sel_wdata;
      cur_port  = gnt_idx;
    end else begin
      cur_rnw   = lrnw;
      cur_addr  = laddr;
      cur_wdata = lwdata;
      cur_port  = owner;
    end
  end

  assign last_wait = (wcnt == 4'(WAIT_STATES - 1));

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:   if (gnt_any)   state_d = ST_SETUP;
      ST_SETUP:                 state_d = ST_ACCESS;
      ST_ACCESS: if (last_wait) state_d = ST_HOLD;
      ST_HOLD:                  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Output logic is decoded from the next state so that the registered SRAM
  // pins carry the values belonging to the state being entered.
  always_comb begin
    ceb_d  = 1'b1;
    oeb_d  = 1'b1;
    rnw_d  = 1'b1;
    oe_d   = 1'b0;
    ack0_d = 1'b0;
    ack1_d = 1'b0;
    addr_d = sram_addr;
    do_d   = sram_data_o;
    case (state_d)
      ST_SETUP: begin
        ceb_d  = 1'b0;
        oeb_d  = ~cur_rnw;
        oe_d   = ~cur_rnw;
        addr_d = cur_addr;
        do_d   = cur_wdata;
      end
      ST_ACCESS: begin
        ceb_d = 1'b0;
        oeb_d = ~cur_rnw;
        rnw_d = cur_rnw;
        oe_d  = ~cur_rnw;
      end
      ST_HOLD: begin
        // rnw returns high here: the write commits on that rising edge while
        // address and data are still driven
        ceb_d  = 1'b0;
        oe_d   = ~cur_rnw;
        ack0_d = ~cur_port;
        ack1_d = cur_port;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sram_ceb     <= 1'b1;
      sram_oeb     <= 1'b1;
      sram_rnw     <= 1'b1;
      sram_data_oe <= 1'b0;
      sram_addr    <= '0;
      sram_data_o  <= '0;
      p0_ack       <= 1'b0;
      p1_ack       <= 1'b0;
      p0_rdata     <= '0;
      p1_rdata     <= '0;
      wcnt         <= '0;
      lrnw         <= 1'b1;
      laddr        <= '0;
      lwdata       <= '0;
    end else begin
      sram_ceb     <= ceb_d;
      sram_oeb     <= oeb_d;
      sram_rnw     <= rnw_d;
      sram_data_oe <= oe_d;
      sram_addr    <= addr_d;
      sram_data_o  <= do_d;
      p0_ack       <= ack0_d;
      p1_ack       <= ack1_d;

      if (take) begin
        lrnw   <= sel_rnw;
        laddr  <= sel_addr;
        lwdata <= sel_wdata;
      end

      if (state == ST_SETUP)       wcnt <= '0;
      else if (state == ST_ACCESS) wcnt <= wcnt + 4'd1;

      // capture on the edge leaving the last ACCESS cycle
      if (state == ST_ACCESS && state_d == ST_HOLD && cur_rnw) begin
        if (cur_port) p1_rdata <= sram_data_i;
        else          p0_rdata <= sram_data_i;
      end
    end
  end

endmodule

// File: tb/tb_sram_arb_ctrl.sv
module tb_sram_arb_ctrl;
  import sram_arb_pkg::*;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // DUT A: WAIT_STATES = 1
  logic        a_p0_req, a_p0_rnw, a_p1_req, a_p1_rnw;
  logic [18:0] a_p0_addr, a_p1_addr;
  logic [7:0]  a_p0_wdata, a_p1_wdata;
  logic        a_p0_ack, a_p1_ack;
  logic [7:0]  a_p0_rdata, a_p1_rdata;
  logic [18:0] a_addr;
  logic [7:0]  a_do, a_di;
  logic        a_oe, a_ceb, a_oeb, a_rnw;

  // DUT B: WAIT_STATES = 3
  logic        b_p0_req, b_p0_rnw, b_p1_req, b_p1_rnw;
  logic [18:0] b_p0_addr, b_p1_addr;
  logic [7:0]  b_p0_wdata, b_p1_wdata;
  logic        b_p0_ack, b_p1_ack;
  logic [7:0]  b_p0_rdata, b_p1_rdata;
  logic [18:0] b_addr;
  logic [7:0]  b_do, b_di;
  logic        b_oe, b_ceb, b_oeb, b_rnw;

  sram_arb_ctrl #(.WAIT_STATES(1)) u_a (
    .clk(clk), .rst(rst),
    .p0_req(a_p0_req), .p0_rnw(a_p0_rnw), .p0_addr(a_p0_addr), .p0_wdata(a_p0_wdata),
    .p0_ack(a_p0_ack), .p0_rdata(a_p0_rdata),
    .p1_req(a_p1_req), .p1_rnw(a_p1_rnw), .p1_addr(a_p1_addr), .p1_wdata(a_p1_wdata),
    .p1_ack(a_p1_ack), .p1_rdata(a_p1_rdata),
    .sram_addr(a_addr), .sram_data_o(a_do), .sram_data_oe(a_oe), .sram_data_i(a_di),
    .sram_ceb(a_ceb), .sram_oeb(a_oeb), .sram_rnw(a_rnw)
  );

  sram_arb_ctrl #(.WAIT_STATES(3)) u_b (
    .clk(clk), .rst(rst),
    .p0_req(b_p0_req), .p0_rnw(b_p0_rnw), .p0_addr(b_p0_addr), .p0_wdata(b_p0_wdata),
    .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata),
    .p1_req(b_p1_req), .p1_rnw(b_p1_rnw), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata),
    .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
    .sram_addr(b_addr), .sram_data_o(b_do), .sram_data_oe(b_oe), .sram_data_i(b_di),
    .sram_ceb(b_ceb), .sram_oeb(b_oeb), .sram_rnw(b_rnw)
  );

  int passed = 0;
  int total  = 0;
  int conflicts = 0;

  // behavioural SRAM for DUT A, fixed read pattern for DUT B
  logic [7:0] mem [logic [18:0]];
  always @(negedge clk) begin
    if (!a_ceb && !a_rnw && a_oe) mem[a_addr] = a_do;
    a_di = (!a_oeb && mem.exists(a_addr)) ? mem[a_addr] : 8'hEE;
    b_di = (!b_oeb) ? 8'h3C : 8'hEE;
    if ((!a_ceb && !a_oeb && !a_rnw) || (a_oe && !a_oeb)) conflicts++;
    if ((!b_ceb && !b_oeb && !b_rnw) || (b_oe && !b_oeb)) conflicts++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one transfer on DUT A from the current IDLE cycle (cycle N) and
  // watch the SRAM pins until the port's ack (bounded).
  task automatic xfer_a(input bit port, input bit rnw, input logic [18:0] addr,
                        input logic [7:0] wd, output int lat, output int rlow,
                        output int olow, output bit addr_bad, output bit other_ack);
    lat = -1; rlow = 0; olow = 0; addr_bad = 0; other_ack = 0;
    if (port) begin
      a_p1_rnw = rnw; a_p1_addr = addr; a_p1_wdata = wd; a_p1_req = 1'b1;
    end else begin
      a_p0_rnw = rnw; a_p0_addr = addr; a_p0_wdata = wd; a_p0_req = 1'b1;
    end
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (!a_ceb && !a_rnw) rlow++;
      if (!a_oeb) olow++;
      if (!a_ceb && a_addr !== addr) addr_bad = 1'b1;
      if (port ? a_p0_ack : a_p1_ack) other_ack = 1'b1;
      if (port ? a_p1_ack : a_p0_ack) begin
        lat = k;
        break;
      end
    end
    a_p0_req = 1'b0;
    a_p1_req = 1'b0;
    tick();
  endtask

  int  lat, rlow, olow, cnt;
  bit  abad, oack, got, who, seen;

  initial begin
    rst = 1'b1;
    a_p0_req = 0; a_p0_rnw = 1; a_p0_addr = '0; a_p0_wdata = '0;
    a_p1_req = 0; a_p1_rnw = 1; a_p1_addr = '0; a_p1_wdata = '0;
    b_p0_req = 0; b_p0_rnw = 1; b_p0_addr = '0; b_p0_wdata = '0;
    b_p1_req = 0; b_p1_rnw = 1; b_p1_addr = '0; b_p1_wdata = '0;
    tick();
    tick();

    chk("rst_ceb",    a_ceb, 1);
    chk("rst_oeb",    a_oeb, 1);
    chk("rst_rnw",    a_rnw, 1);
    chk("rst_oe",     a_oe, 0);
    chk("rst_addr",   a_addr, 0);
    chk("rst_data_o", a_do, 0);
    chk("rst_acks",   {a_p0_ack, a_p1_ack}, 0);
    chk("rst_rdata",  {a_p0_rdata, a_p1_rdata}, 0);
    chk("rst_b_ceb",  b_ceb, 1);

    rst = 1'b0;
    tick();
    chk("idle_ceb", a_ceb, 1);

    // p0 write 0x5A9 <- 0xC3
    xfer_a(1'b0, 1'b0, 19'h005A9, 8'hC3, lat, rlow, olow, abad, oack);
    chk("wr_latency",   lat, 3);
    chk("wr_rnw_low",   rlow, 1);
    chk("wr_oeb_low",   olow, 0);
    chk("wr_addr_stab", abad, 0);
    chk("wr_p1_ack",    oack, 0);

    // p1 read back
    xfer_a(1'b1, 1'b1, 19'h005A9, 8'h00, lat, rlow, olow, abad, oack);
    chk("rd_latency",  lat, 3);
    chk("rd_rdata",    a_p1_rdata, 8'hC3);
    chk("rd_oeb_low",  olow, 2);
    chk("rd_rnw_low",  rlow, 0);
    chk("rd_p0_ack",   oack, 0);
    chk("rd_p0_rdata", a_p0_rdata, 0);

    // both ports request continuously for 4 rounds
    a_p0_rnw = 1; a_p0_addr = 19'h005A9;
    a_p1_rnw = 1; a_p1_addr = 19'h005A9;
    a_p0_req = 1; a_p1_req = 1;
    for (int r = 0; r < 4; r++) begin
      cnt = 0; got = 0; who = 0;
      for (int k = 1; k <= 20; k++) begin
        tick();
        cnt++;
        if (a_p0_ack || a_p1_ack) begin
          got = 1; who = a_p1_ack;
          chk("arb_one_ack", a_p0_ack & a_p1_ack, 0);
          break;
        end
      end
      chk($sformatf("arb_who_r%0d", r), who, RR ? (r % 2) : 0);
      chk($sformatf("arb_gap_r%0d", r), got ? cnt : -1, (r == 0) ? 3 : 4);
    end
    // p0 lets go; the pending p1 request is served next
    a_p0_req = 0;
    cnt = 0; got = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      cnt++;
      if (a_p1_ack) begin got = 1; break; end
    end
    chk("arb_p1_after", got ? cnt : -1, 4);
    a_p1_req = 0;
    tick();
    chk("arb_p0_rdata", a_p0_rdata, 8'hC3);

    // reset during ACCESS of a write to 0x7FFFF
    a_p0_rnw = 0; a_p0_addr = 19'h7FFFF; a_p0_wdata = 8'h5A; a_p0_req = 1;
    tick();
    tick();
    chk("abort_in_access", {a_ceb, a_rnw}, 2'b00);
    rst = 1; a_p0_req = 0;
    tick();
    chk("abort_ceb",   a_ceb, 1);
    chk("abort_oeb",   a_oeb, 1);
    chk("abort_rnw",   a_rnw, 1);
    chk("abort_oe",    a_oe, 0);
    chk("abort_ack",   {a_p0_ack, a_p1_ack}, 0);
    chk("abort_state", 32'(u_a.state), 32'(ST_IDLE));
    rst = 0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (a_p0_ack || a_p1_ack || !a_ceb) seen = 1;
    end
    chk("abort_quiet", seen, 0);

    // WAIT_STATES = 3 read of address 0
    b_p0_rnw = 1; b_p0_addr = 19'h00000; b_p0_req = 1;
    lat = -1; olow = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (!b_oeb) olow++;
      if (b_p0_ack) begin lat = k; break; end
    end
    b_p0_req = 0;
    tick();
    chk("ws3_latency", lat, 5);
    chk("ws3_oeb_low", olow, 4);
    chk("ws3_rdata",   b_p0_rdata, 8'h3C);
    chk("ws3_p1_ack",  b_p1_ack, 0);

    chk("strobe_conflicts", conflicts, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
